// File: rtl/generador_tonos_if.sv
// generador_tonos_if: valid/ready frequency-request port of the tone generator
interface generador_tonos_if #(
  parameter int CH_W   = 2,
  parameter int FREQ_W = 16
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [FREQ_W-1:0] cfg_freq;
  modport master (output cfg_valid, cfg_ch, cfg_freq, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_freq, output cfg_ready);
endinterface

// File: rtl/generador_tonos.sv
// generador_tonos: multi-channel square-wave generator, half-periods from one shared serial divider
module generador_tonos #(
  parameter int CLK_HZ   = 50000000,
  parameter int CHANNELS = 4,
  parameter int FREQ_W   = 16,
  parameter int DIV_W    = 26,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  generador_tonos_if.slave    cfg,
  input  logic [CHANNELS-1:0] ch_en,
  output logic [CHANNELS-1:0] tone_out
);
  typedef enum logic [1:0] {IDLE, DIV, COMMIT} state_t;
  localparam logic [63:0] MAX64 = (64'd1 << DIV_W) - 64'd1;
  localparam logic [31:0] MAX   = MAX64[31:0];
  state_t            state_q;
  logic              ready_q;
  logic [CH_W-1:0]   ch_q;
  logic [FREQ_W-1:0] freq_q;
  logic [FREQ_W:0]   dsr_q, rem_q, rem_d;
  logic [31:0]       quo_q;
  logic [4:0]        bit_q;
  logic [FREQ_W+1:0] rem_sh;
  logic              ge;
  logic [DIV_W-1:0]  res;
  logic              commit;
  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    ge     = rem_sh >= {1'b0, dsr_q};
    rem_d  = ge ? (FREQ_W+1)'(rem_sh - {1'b0, dsr_q}) : rem_sh[FREQ_W:0];
    res    = freq_q == '0 ? '0 :
             quo_q == '0 ? DIV_W'(1) :
             quo_q > MAX ? MAX[DIV_W-1:0] : quo_q[DIV_W-1:0];
    commit = state_q == COMMIT;
  end
  assign cfg.cfg_ready = ready_q;
  // restoring division: remainder and quotient shift left together, one quotient bit per cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      bit_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (cfg.cfg_valid && ready_q) begin
          ch_q    <= cfg.cfg_ch;
          freq_q  <= cfg.cfg_freq;
          dsr_q   <= {cfg.cfg_freq, 1'b0};
          quo_q   <= 32'(CLK_HZ);
          rem_q   <= '0;
          bit_q   <= '0;
          ready_q <= 1'b0;
          state_q <= DIV;
        end
        DIV: begin
          rem_q   <= rem_d;
          quo_q   <= {quo_q[30:0], ge};
          bit_q   <= bit_q + 5'd1;
          state_q <= bit_q == 5'd31 ? COMMIT : DIV;
        end
        COMMIT: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DIV_W-1:0] half_q, pend_val_q, cnt_q;
    logic             pend_q, tone_q;
    logic             hit;
    assign hit         = commit && ch_q == CH_W'(c);
    assign tone_out[c] = tone_q;
    // commit is evaluated last so it overrides the free-running update in the same cycle
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        half_q     <= '0;
        pend_val_q <= '0;
        cnt_q      <= '0;
        pend_q     <= 1'b0;
        tone_q     <= 1'b0;
      end else begin
        if (!ch_en[c] || half_q == '0) begin
          cnt_q  <= '0;
          tone_q <= 1'b0;
          if (pend_q) begin
            half_q <= pend_val_q;
            pend_q <= 1'b0;
          end
        end else if (cnt_q == half_q - DIV_W'(1)) begin
          tone_q <= ~tone_q;
          cnt_q  <= '0;
          if (pend_q) begin
            half_q <= pend_val_q;
            pend_q <= 1'b0;
          end
        end else begin
          cnt_q <= cnt_q + DIV_W'(1);
        end
        if (hit) begin
          if (res == '0) begin
            half_q <= '0;
            pend_q <= 1'b0;
          end else if (half_q == '0) begin
            half_q <= res;
            cnt_q  <= '0;
          end else begin
            pend_val_q <= res;
            pend_q     <= 1'b1;
          end
        end
      end
    end
  end
endmodule
